// File: rtl/kbd_pwm_array.sv
// kbd_pwm_array
//   Multi-channel PWM generator driven by a PS/2 keyboard byte stream.
//   Number keys '1'..'8' select a channel and edit keys change that
//   channel's target duty. Each channel's applied duty moves toward its
//   target only at a PWM period boundary, so an output period is never cut
//   short or stretched by a key press.
//
// Ports
//   clk       in   1      pixel clock
//   reset     in   1      asynchronous reset, active low
//   scancode  in   8      PS/2 byte from the keyboard receiver
//   flag      in   1      one-cycle strobe: scancode is valid
//   pwm       out  N_CH   PWM outputs, bit i belongs to channel i
//   sel       out  3      index of the currently selected channel
//   busy      out  1      high while any applied duty differs from its target
module kbd_pwm_array #(
    parameter int N_CH      = 4,
    parameter int RES       = 8,
    parameter int PRESCALE  = 16,
    parameter int STEP      = 16,
    parameter int RAMP_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      scancode,
    input  logic            flag,
    output logic [N_CH-1:0] pwm,
    output logic [2:0]      sel,
    output logic            busy
);

    localparam int              PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
    localparam logic [RES-1:0]  DUTY_MAX = {RES{1'b1}};
    localparam logic [RES-1:0]  CNT_LAST = DUTY_MAX - 1'b1;
    localparam logic [RES:0]    STEP_W   = (RES + 1)'(STEP);
    localparam logic [RES:0]    RAMP_W   = (RES + 1)'(RAMP_STEP);

    typedef enum logic {
        IDLE,
        BREAK
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [PSC_W-1:0] psc;
    logic [RES-1:0]   cnt;
    logic [RES-1:0]   tgt [N_CH];
    logic [RES-1:0]   act [N_CH];
    logic             tick;
    logic             pend;
    logic             make;
    logic [3:0]       key_idx;
    logic             any_diff;

    // Duty arithmetic is done with a guard bit and a sign bit so that both
    // overflow past full scale and underflow below zero clamp instead of wrapping.
    function automatic logic [RES-1:0] clamp_duty(input logic signed [RES+1:0] x);
        if (x < 0)
            return '0;
        else if (x > $signed({2'b00, DUTY_MAX}))
            return DUTY_MAX;
        else
            return x[RES-1:0];
    endfunction

    function automatic logic [RES-1:0] edit_duty(input logic [7:0] code,
                                                 input logic [RES-1:0] v);
        logic signed [RES+1:0] v_s;
        logic signed [RES+1:0] step_s;
        v_s    = $signed({2'b00, v});
        step_s = $signed({1'b0, STEP_W});
        case (code)
            8'h55:   return clamp_duty(v_s + step_s);
            8'h4E:   return clamp_duty(v_s - step_s);
            8'h45:   return '0;
            8'h2B:   return DUTY_MAX;
            default: return v;
        endcase
    endfunction

    function automatic logic [RES-1:0] ramp_duty(input logic [RES-1:0] a,
                                                 input logic [RES-1:0] t);
        logic signed [RES+1:0] a_s;
        logic signed [RES+1:0] diff;
        logic signed [RES+1:0] rs_s;
        a_s  = $signed({2'b00, a});
        diff = $signed({2'b00, t}) - a_s;
        rs_s = $signed({1'b0, RAMP_W});
        if (RAMP_STEP == 0)
            return t;
        else if (diff > rs_s)
            return clamp_duty(a_s + rs_s);
        else if (diff < -rs_s)
            return clamp_duty(a_s - rs_s);
        else
            return t;
    endfunction

    // Number-row make codes '1'..'8' map to channel 0..7; 8 means "not a number key".
    function automatic logic [3:0] key_to_idx(input logic [7:0] code);
        case (code)
            8'h16:   return 4'd0;
            8'h1E:   return 4'd1;
            8'h26:   return 4'd2;
            8'h25:   return 4'd3;
            8'h2E:   return 4'd4;
            8'h36:   return 4'd5;
            8'h3D:   return 4'd6;
            8'h3E:   return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

    assign tick    = (psc == PSC_LAST);
    assign pend    = tick && (cnt == CNT_LAST);
    assign key_idx = key_to_idx(scancode);
    // E0 is only a prefix; the code that follows it is handled like any other.
    assign make    = flag && (state == IDLE) && (scancode != 8'hF0) && (scancode != 8'hE0);

    always_comb begin
        state_nx = state;
        if (flag) begin
            case (state)
                IDLE:    if (scancode == 8'hF0) state_nx = BREAK;
                BREAK:   state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        any_diff = 1'b0;
        for (int i = 0; i < N_CH; i++)
            any_diff = any_diff | (act[i] != tgt[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            psc   <= '0;
            cnt   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            pwm   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                tgt[i] <= '0;
                act[i] <= '0;
            end
        end else begin
            state <= state_nx;
            busy  <= any_diff;
            psc   <= tick ? '0 : psc + 1'b1;
            if (tick)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (make && (key_idx < 4'(N_CH)))
                sel <= key_idx[2:0];
            for (int i = 0; i < N_CH; i++) begin
                pwm[i] <= (cnt < act[i]);
                // The ramp reads the registered target, so a key arriving in
                // the pend cycle only takes effect at the following boundary.
                if (pend)
                    act[i] <= ramp_duty(act[i], tgt[i]);
                if (make && (sel == 3'(i)))
                    tgt[i] <= edit_duty(scancode, tgt[i]);
            end
        end
    end

endmodule

// File: tb/tb_kbd_pwm_array.sv
// Bench for kbd_pwm_array: two instances share one keyboard stream, one
// ramping (RAMP_STEP=2) and one jumping (RAMP_STEP=0). A reference model
// predicts pwm/sel/busy every cycle from elapsed-cycle arithmetic, and
// duty measurements over whole periods are compared against the expected
// high time.
module tb_kbd_pwm_array;

    localparam int P    = 2;
    localparam int RES  = 6;
    localparam int PER  = 63;
    localparam int NCH  = 4;
    localparam int STEP = 8;
    localparam int RS   = 2;
    localparam int MAXV = 63;

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     scancode = 8'h00;
    logic           flag = 1'b0;
    logic [NCH-1:0] pwm_a, pwm_b;
    logic [2:0]     sel_a, sel_b;
    logic           busy_a, busy_b;

    int total = 0;
    int bad   = 0;

    int n;
    bit brk;
    int m_sel;
    int m_tgt [NCH];
    int m_act [2][NCH];
    int m_pwm [2];
    int m_busy[2];

    kbd_pwm_array #(.N_CH(NCH), .RES(RES), .PRESCALE(P), .STEP(STEP), .RAMP_STEP(RS)) dut_a (
        .clk(clk), .reset(reset), .scancode(scancode), .flag(flag),
        .pwm(pwm_a), .sel(sel_a), .busy(busy_a));

    kbd_pwm_array #(.N_CH(NCH), .RES(RES), .PRESCALE(P), .STEP(STEP), .RAMP_STEP(0)) dut_b (
        .clk(clk), .reset(reset), .scancode(scancode), .flag(flag),
        .pwm(pwm_b), .sel(sel_b), .busy(busy_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ramp_m(input int a, input int t, input int rs);
        if (rs == 0) return t;
        if (t > a) return a + ((t - a < rs) ? t - a : rs);
        return a - ((a - t < rs) ? a - t : rs);
    endfunction

    function automatic int key_ch(input logic [7:0] c);
        case (c)
            8'h16: return 0;  8'h1E: return 1;  8'h26: return 2;  8'h25: return 3;
            8'h2E: return 4;  8'h36: return 5;  8'h3D: return 6;  8'h3E: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        n = 0; brk = 0; m_sel = 0;
        for (int k = 0; k < 2; k++) begin
            m_pwm[k] = 0; m_busy[k] = 0;
            for (int c = 0; c < NCH; c++) m_act[k][c] = 0;
        end
        for (int c = 0; c < NCH; c++) m_tgt[c] = 0;
    endtask

    // Predict the outputs after the coming clock edge from the state before it.
    task automatic model_step(input bit f, input logic [7:0] c);
        int  tick_pos;
        bit  period_end;
        int  ch;
        tick_pos   = (n / P) % PER;
        period_end = ((n + 1) % (P * PER)) == 0;
        for (int k = 0; k < 2; k++) begin
            m_pwm[k] = 0; m_busy[k] = 0;
            for (int i = 0; i < NCH; i++) begin
                if (tick_pos < m_act[k][i]) m_pwm[k] |= (1 << i);
                if (m_act[k][i] != m_tgt[i]) m_busy[k] = 1;
                if (period_end) m_act[k][i] = ramp_m(m_act[k][i], m_tgt[i], (k == 0) ? RS : 0);
            end
        end
        if (f) begin
            if (brk) brk = 0;
            else if (c == 8'hF0) brk = 1;
            else if (c != 8'hE0) begin
                case (c)
                    8'h55: m_tgt[m_sel] = (m_tgt[m_sel] + STEP > MAXV) ? MAXV : m_tgt[m_sel] + STEP;
                    8'h4E: m_tgt[m_sel] = (m_tgt[m_sel] - STEP < 0) ? 0 : m_tgt[m_sel] - STEP;
                    8'h45: m_tgt[m_sel] = 0;
                    8'h2B: m_tgt[m_sel] = MAXV;
                    default: begin
                        ch = key_ch(c);
                        if (ch >= 0 && ch < NCH) m_sel = ch;
                    end
                endcase
            end
        end
        n++;
    endtask

    task automatic check_out();
        chk("pwm_a", pwm_a, m_pwm[0]);
        chk("pwm_b", pwm_b, m_pwm[1]);
        chk("sel_a", sel_a, m_sel);
        chk("sel_b", sel_b, m_sel);
        chk("busy_a", busy_a, m_busy[0]);
        chk("busy_b", busy_b, m_busy[1]);
    endtask

    // Called at a falling edge: drive inputs, predict, let one rising edge pass, check.
    task automatic step(input bit f, input logic [7:0] c);
        flag = f; scancode = c;
        if (reset) model_step(f, c);
        @(negedge clk);
        flag = 1'b0;
        check_out();
    endtask

    task automatic send(input logic [7:0] c);
        step(1'b1, c);
        repeat (1 + $urandom_range(0, 3)) step(1'b0, 8'h00);
    endtask

    function automatic bit settled();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NCH; i++)
                if (m_act[k][i] != m_tgt[i]) return 0;
        return 1;
    endfunction

    task automatic settle();
        int guard = 0;
        while (!settled() && guard < 40 * P * PER) begin
            step(1'b0, 8'h00);
            guard++;
        end
        if (!settled()) chk("settle_timeout", 0, 1);
        repeat (3) step(1'b0, 8'h00);
        chk("busy_a_idle", busy_a, 0);
        chk("busy_b_idle", busy_b, 0);
    endtask

    // Measure one whole period aligned to a boundary; optionally inject a
    // key on step key_at. High counts are compared against the duty the
    // model held at the start of the window.
    task automatic measure(input int key_at, input logic [7:0] key,
                           output int hi_a[NCH], output int hi_b[NCH]);
        int exp_a[NCH];
        int exp_b[NCH];
        while ((n % (P * PER)) != 0) step(1'b0, 8'h00);
        for (int i = 0; i < NCH; i++) begin
            hi_a[i] = 0; hi_b[i] = 0;
            exp_a[i] = m_act[0][i] * P; exp_b[i] = m_act[1][i] * P;
        end
        for (int s = 0; s < P * PER; s++) begin
            step(s == key_at, (s == key_at) ? key : 8'h00);
            for (int i = 0; i < NCH; i++) begin
                hi_a[i] += int'(pwm_a[i]);
                hi_b[i] += int'(pwm_b[i]);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("hi_a[%0d]", i), hi_a[i], exp_a[i]);
            chk($sformatf("hi_b[%0d]", i), hi_b[i], exp_b[i]);
        end
    endtask

    logic [7:0] codes [16] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h36, 8'h55, 8'h55, 8'h4E,
                               8'h4E, 8'h45, 8'h2B, 8'hF0, 8'hE0, 8'h3E, 8'h55, 8'h4E};

    initial begin
        int ha[NCH];
        int hb[NCH];
        logic [7:0] c;

        // Reset held: inputs toggling must not disturb anything.
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_out();
        step(1'b1, 8'h2B); step(1'b1, 8'h55); step(1'b1, 8'h1E); step(1'b1, 8'h55);
        reset = 1'b1;
        repeat (P * PER) step(1'b0, 8'h00);
        chk("pwm_a_after_release", pwm_a, 0);

        // Select channel 1, raise to 3*STEP.
        send(8'h1E); send(8'h55); send(8'h55); send(8'h55);
        chk("sel_key2", sel_a, 1);
        chk("busy_ramping", busy_a, 1);
        settle();
        measure(-1, 8'h00, ha, hb);
        chk("duty_24", ha[1], 24 * P);

        // Break and extended-break sequences leave the target alone.
        send(8'hF0); send(8'h55); send(8'hE0); send(8'hF0); send(8'h4E);
        send(8'h55);
        settle();
        measure(-1, 8'h00, ha, hb);
        chk("duty_32", ha[1], 32 * P);

        // Saturation at both ends.
        send(8'h2B); send(8'h55);
        settle();
        measure(-1, 8'h00, ha, hb);
        chk("duty_full", ha[1], P * PER);
        send(8'h45); send(8'h4E);
        settle();
        measure(-1, 8'h00, ha, hb);
        chk("duty_zero", hb[1], 0);

        // Key '6' is beyond N_CH; then give every channel its own duty.
        send(8'h36);
        chk("sel_ignored", sel_b, 1);
        send(8'h16); send(8'h55); send(8'h55);
        send(8'h1E); send(8'h55); send(8'h55); send(8'h55); send(8'h55);
        send(8'h26); send(8'h55); send(8'h55); send(8'h55); send(8'h55); send(8'h55); send(8'h55);
        send(8'h25); send(8'h2B); send(8'h4E);
        chk("sel_ch3", sel_a, 3);
        settle();
        measure(-1, 8'h00, ha, hb);
        chk("ch0_16", ha[0], 16 * P);
        chk("ch1_32", ha[1], 32 * P);
        chk("ch2_48", ha[2], 48 * P);
        chk("ch3_55", hb[3], 55 * P);

        // Key landing on the period-end cycle is applied one period later.
        measure(P * PER - 1, 8'h55, ha, hb);
        chk("pend_key_cur", hb[3], 55 * P);
        measure(-1, 8'h00, ha, hb);
        chk("pend_key_next", hb[3], 55 * P);
        measure(-1, 8'h00, ha, hb);
        chk("pend_key_late", hb[3], MAXV * P);
        // Mid-period change does not alter the period in progress.
        measure(40, 8'h4E, ha, hb);
        chk("mid_change_cur", hb[3], MAXV * P);
        measure(-1, 8'h00, ha, hb);
        chk("mid_change_next", hb[3], 55 * P);

        // Random key traffic with an asynchronous reset in the middle.
        for (int s = 0; s < 4000; s++) begin
            if (s == 2000) begin
                #2 reset = 1'b0;
                #1 model_reset();
                chk("async_pwm_a", pwm_a, 0);
                chk("async_sel", sel_a, 0);
                chk("async_busy", busy_a, 0);
                repeat (3) step(1'b1, 8'h55);
                reset = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) begin
                c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : codes[$urandom_range(0, 15)];
                step(1'b1, c);
            end else begin
                step(1'b0, 8'h00);
            end
        end
        settle();
        measure(-1, 8'h00, ha, hb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
